// File: rtl/tjmono2_rx_tap_scan_if.sv
// Bus between the tap-scan sequencer (master) and the RX core register file (slave).
interface tjmono2_rx_tap_scan_if #(
  parameter int ABUSWIDTH = 32
);
  logic [ABUSWIDTH-1:0] M_BUS_ADD;
  logic [7:0]           M_BUS_DATA_OUT;
  logic [7:0]           M_BUS_DATA_IN;
  logic                 M_BUS_WR;
  logic                 M_BUS_RD;

  modport master (
    output M_BUS_ADD,
    output M_BUS_DATA_OUT,
    output M_BUS_WR,
    output M_BUS_RD,
    input  M_BUS_DATA_IN
  );

  modport slave (
    input  M_BUS_ADD,
    input  M_BUS_DATA_OUT,
    input  M_BUS_WR,
    input  M_BUS_RD,
    output M_BUS_DATA_IN
  );
endinterface

// File: rtl/tjmono2_rx_tap_scan.sv
// IODELAY tap-scan link trainer for one TJ-Monopix2 RX channel; picks the centre of the longest passing window.
// Optional: define TAP_SCAN_BOTH_EDGES_EN to scan both sampling edges instead of CONF_EDGE only.
module tjmono2_rx_tap_scan #(
  parameter int ABUSWIDTH     = 32,
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic                   BUS_CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic                   CONF_INVERT,
  input  logic                   CONF_EDGE,
  tjmono2_rx_tap_scan_if.master  m_bus,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   FAIL,
  output logic [4:0]             BEST_TAP,
  output logic                   BEST_EDGE,
  output logic [6:0]             BEST_LEN,
  output logic [63:0]            PASS_MAP
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  localparam logic [ABUSWIDTH-1:0] ADDR_SOFT_RST = ABUSWIDTH'(0);
  localparam logic [ABUSWIDTH-1:0] ADDR_CTRL     = ABUSWIDTH'(2);
  localparam logic [ABUSWIDTH-1:0] ADDR_ERR_CNT  = ABUSWIDTH'(5);
  localparam logic [ABUSWIDTH-1:0] ADDR_TAP      = ABUSWIDTH'(7);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_WR, S_TAP_WR, S_EN_WR, S_SETTLE,
    S_RD_STAT, S_RD_STAT_W, S_RD_ERR, S_RD_ERR_W, S_EVAL,
    S_FIN_RST, S_FIN_TAP, S_FIN_EN, S_DONE
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [4:0]           r_tap;
  logic                 r_edge;
  logic                 r_ready;
  logic                 r_err_zero;
  logic [4:0]           r_run_start;
  logic [6:0]           r_run_len;
  logic [ABUSWIDTH-1:0] r_add;
  logic [7:0]           r_dout;
  logic                 r_wr;
  logic                 r_rd;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_fail;
  logic [4:0]           r_best_tap;
  logic                 r_best_edge;
  logic [6:0]           r_best_len;
  logic [63:0]          r_pass_map;

  logic       w_pass;
  logic [6:0] w_run_prev;
  logic [4:0] w_run_start;
  logic [6:0] w_run_len;
  logic       w_better;
  logic [4:0] w_center;
  logic       w_last;
  logic       w_first_edge;
  logic [7:0] w_en_data;
  logic [7:0] w_fin_tap_data;

`ifdef TAP_SCAN_BOTH_EDGES_EN
  logic w_unused_conf_edge;
  assign w_unused_conf_edge = CONF_EDGE;
  assign w_first_edge       = 1'b0;
  assign w_last             = (r_tap == 5'd31) && r_edge;
`else
  assign w_first_edge       = CONF_EDGE;
  assign w_last             = (r_tap == 5'd31);
`endif

  // Runs restart at tap 0 so windows never wrap 31 -> 0 or span the two edges.
  assign w_pass      = r_ready & r_err_zero;
  assign w_run_prev  = (r_tap == 5'd0) ? 7'd0 : r_run_len;
  assign w_run_start = (w_run_prev == 7'd0) ? r_tap : r_run_start;
  assign w_run_len   = w_pass ? (w_run_prev + 7'd1) : 7'd0;
  assign w_better    = w_pass && (w_run_len > r_best_len);
  assign w_center    = w_run_start + 5'((w_run_len - 7'd1) >> 1);

  assign w_en_data      = {5'b0, 1'b1, CONF_INVERT, 1'b0};
  assign w_fin_tap_data = r_fail ? 8'h22 : {2'b00, r_best_edge, r_best_tap};

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tap       <= '0;
      r_edge      <= 1'b0;
      r_ready     <= 1'b0;
      r_err_zero  <= 1'b0;
      r_run_start <= '0;
      r_run_len   <= '0;
      r_add       <= '0;
      r_dout      <= '0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_best_tap  <= '0;
      r_best_edge <= 1'b0;
      r_best_len  <= '0;
      r_pass_map  <= '0;
    end else begin
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_done <= 1'b0;
      if (ABORT && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (START) begin
              r_state     <= S_RST_WR;
              r_busy      <= 1'b1;
              r_tap       <= '0;
              r_edge      <= w_first_edge;
              r_run_len   <= '0;
              r_fail      <= 1'b0;
              r_best_tap  <= '0;
              r_best_edge <= 1'b0;
              r_best_len  <= '0;
              r_pass_map  <= '0;
              r_wr        <= 1'b1;
              r_add       <= ADDR_SOFT_RST;
              r_dout      <= 8'h00;
            end
          end
          S_RST_WR: begin
            r_state <= S_TAP_WR;
            r_wr    <= 1'b1;
            r_add   <= ADDR_TAP;
            r_dout  <= {2'b00, r_edge, r_tap};
          end
          S_TAP_WR: begin
            r_state <= S_EN_WR;
            r_wr    <= 1'b1;
            r_add   <= ADDR_CTRL;
            r_dout  <= w_en_data;
          end
          S_EN_WR: begin
            r_state <= S_SETTLE;
            r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
          end
          S_SETTLE: begin
            if (r_cnt == '0) begin
              r_state <= S_RD_STAT;
              r_rd    <= 1'b1;
              r_add   <= ADDR_CTRL;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_RD_STAT: r_state <= S_RD_STAT_W;
          S_RD_STAT_W: begin
            r_ready <= m_bus.M_BUS_DATA_IN[0];
            r_state <= S_RD_ERR;
            r_rd    <= 1'b1;
            r_add   <= ADDR_ERR_CNT;
          end
          S_RD_ERR: r_state <= S_RD_ERR_W;
          S_RD_ERR_W: begin
            r_err_zero <= (m_bus.M_BUS_DATA_IN == 8'h00);
            r_state    <= S_EVAL;
          end
          S_EVAL: begin
            r_pass_map[{r_edge, r_tap}] <= w_pass;
            r_run_start <= w_run_start;
            r_run_len   <= w_run_len;
            if (w_better) begin
              r_best_len  <= w_run_len;
              r_best_edge <= r_edge;
              r_best_tap  <= w_center;
            end
            r_wr   <= 1'b1;
            r_add  <= ADDR_SOFT_RST;
            r_dout <= 8'h00;
            if (w_last) begin
              r_state <= S_FIN_RST;
              r_fail  <= !w_better && (r_best_len == 7'd0);
            end else begin
              r_state <= S_RST_WR;
              r_tap   <= r_tap + 5'd1;
              if (r_tap == 5'd31) r_edge <= 1'b1;
            end
          end
          S_FIN_RST: begin
            r_state <= S_FIN_TAP;
            r_wr    <= 1'b1;
            r_add   <= ADDR_TAP;
            r_dout  <= w_fin_tap_data;
          end
          S_FIN_TAP: begin
            r_state <= S_FIN_EN;
            r_wr    <= 1'b1;
            r_add   <= ADDR_CTRL;
            r_dout  <= w_en_data;
          end
          S_FIN_EN: begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign m_bus.M_BUS_ADD      = r_add;
  assign m_bus.M_BUS_DATA_OUT = r_dout;
  assign m_bus.M_BUS_WR       = r_wr;
  assign m_bus.M_BUS_RD       = r_rd;

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign FAIL      = r_fail;
  assign BEST_TAP  = r_best_tap;
  assign BEST_EDGE = r_best_edge;
  assign BEST_LEN  = r_best_len;
  assign PASS_MAP  = r_pass_map;

endmodule

// File: tb/tb_tjmono2_rx_tap_scan.sv
// Bench for tjmono2_rx_tap_scan: RX register-file responder, write scoreboard and bus protocol monitor.
module tb_tjmono2_rx_tap_scan;
  localparam int S  = 16;
  localparam int AW = 32;
`ifdef TAP_SCAN_BOTH_EDGES_EN
  localparam int NT = 64;
`else
  localparam int NT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort, conf_inv, conf_edge;
  logic        busy, done, fail_o, best_edge;
  logic [4:0]  best_tap;
  logic [6:0]  best_len;
  logic [63:0] pass_map;

  tjmono2_rx_tap_scan_if #(.ABUSWIDTH(AW)) bus ();

  tjmono2_rx_tap_scan #(.ABUSWIDTH(AW), .SETTLE_CYCLES(S)) dut (
    .BUS_CLK(clk), .RST(rst), .START(start), .ABORT(abort),
    .CONF_INVERT(conf_inv), .CONF_EDGE(conf_edge), .m_bus(bus),
    .BUSY(busy), .DONE(done), .FAIL(fail_o), .BEST_TAP(best_tap),
    .BEST_EDGE(best_edge), .BEST_LEN(best_len), .PASS_MAP(pass_map)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int done_cnt = 0, rd_cnt = 0;
  logic [39:0] exp_wr[$];
  logic [63:0] cfg = '0;
  int fail_mode = 0;
  logic [4:0] cur_tap = '0;
  logic cur_edge = 1'b0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_wadd = '0;

  // RX core model (read data valid from the cycle after RD) plus protocol/write checking.
  always @(negedge clk) begin
    logic p, rdy;
    logic [7:0] errv;
    logic [39:0] e;
    if (bus.M_BUS_WR || bus.M_BUS_RD) begin
      checks++;
      if (bus.M_BUS_WR && bus.M_BUS_RD) begin
        errors++; $display("FAIL strobe_overlap wr=%0b rd=%0b want not both", bus.M_BUS_WR, bus.M_BUS_RD);
      end
    end
    if (bus.M_BUS_RD) begin
      rd_cnt++;
      checks++;
      if (prev_rd) begin errors++; $display("FAIL rd_width got 2+ cycles want 1 at cycle %0d", cyc); end
      p    = cfg[{cur_edge, cur_tap}];
      rdy  = p ? 1'b1 : ((fail_mode != 0) ? 1'b1 : ~cur_tap[0]);
      errv = p ? 8'h00 : ((fail_mode != 0) ? 8'h01 : (cur_tap[0] ? 8'h00 : 8'h10));
      checks++;
      if (bus.M_BUS_ADD == 32'd2) bus.M_BUS_DATA_IN = 8'hF0 | {7'b0, rdy};
      else if (bus.M_BUS_ADD == 32'd5) bus.M_BUS_DATA_IN = errv;
      else begin errors++; $display("FAIL rd_addr got %0h want 2 or 5", bus.M_BUS_ADD); end
    end
    if (bus.M_BUS_WR) begin
      checks++;
      if (prev_wr && prev_wadd == bus.M_BUS_ADD) begin
        errors++; $display("FAIL wr_width addr %0h held 2+ cycles want 1", bus.M_BUS_ADD);
      end
      if (bus.M_BUS_ADD == 32'd7) begin
        cur_tap  = bus.M_BUS_DATA_OUT[4:0];
        cur_edge = bus.M_BUS_DATA_OUT[5];
      end
      checks++;
      if (exp_wr.size() == 0) begin
        errors++; $display("FAIL unexpected_write got addr %0h data %0h want none", bus.M_BUS_ADD, bus.M_BUS_DATA_OUT);
      end else begin
        e = exp_wr.pop_front();
        if ({bus.M_BUS_ADD, bus.M_BUS_DATA_OUT} !== e)
          begin errors++; $display("FAIL write got addr %0h data %0h want addr %0h data %0h", bus.M_BUS_ADD, bus.M_BUS_DATA_OUT, e[39:8], e[7:0]); end
      end
    end
    if (done) done_cnt++;
    prev_rd   = bus.M_BUS_RD;
    prev_wr   = bus.M_BUS_WR;
    prev_wadd = bus.M_BUS_ADD;
  end

  task automatic push_w(input logic [31:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic push_taps(input logic e, input int t_from, input int t_to, input logic inv);
    for (int t = t_from; t <= t_to; t++) begin
      push_w(32'd0, 8'h00);
      push_w(32'd7, 8'({e, 5'(t)}));
      push_w(32'd2, {5'b0, 1'b1, inv, 1'b0});
    end
  endtask

  task automatic push_full(input logic e, input logic inv);
`ifdef TAP_SCAN_BOTH_EDGES_EN
    push_taps(1'b0, 0, 31, inv);
    push_taps(1'b1, 0, 31, inv);
`else
    push_taps(e, 0, 31, inv);
`endif
  endtask

  task automatic push_fin(input logic [7:0] r7, input logic inv);
    push_w(32'd0, 8'h00);
    push_w(32'd7, r7);
    push_w(32'd2, {5'b0, 1'b1, inv, 1'b0});
  endtask

  int          sc_lat;
  bit          sc_tmo, sc_busy1, sc_fail1, sc_busy_done;
  logic [63:0] sc_pmap1;

  // Drives one START, optionally re-pulses START mid-scan, waits (bounded) for DONE.
  task automatic do_scan(input logic e, input logic inv, input int glitch_at);
    int t0;
    conf_edge = e;
    conf_inv  = inv;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start    = 1'b0;
    sc_busy1 = busy;
    sc_fail1 = fail_o;
    sc_pmap1 = pass_map;
    while (!done && (cyc - t0) < 5000) begin
      @(negedge clk);
      start = (glitch_at > 0) && ((cyc - t0) == glitch_at);
    end
    start        = 1'b0;
    sc_tmo       = !done;
    sc_lat       = cyc - t0;
    sc_busy_done = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; conf_inv = 1'b0; conf_edge = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (fail_o !== 1'b0) begin errors++; $display("FAIL reset_fail got %0b want 0", fail_o); end
    checks++; if (best_tap !== 5'd0) begin errors++; $display("FAIL reset_best_tap got %0d want 0", best_tap); end
    checks++; if (best_edge !== 1'b0) begin errors++; $display("FAIL reset_best_edge got %0b want 0", best_edge); end
    checks++; if (best_len !== 7'd0) begin errors++; $display("FAIL reset_best_len got %0d want 0", best_len); end
    checks++; if (pass_map !== 64'd0) begin errors++; $display("FAIL reset_pass_map got %0h want 0", pass_map); end
    checks++; if ({bus.M_BUS_WR, bus.M_BUS_RD} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %0b want 0", {bus.M_BUS_WR, bus.M_BUS_RD}); end
    checks++; if ({bus.M_BUS_ADD, bus.M_BUS_DATA_OUT} !== 40'd0) begin errors++; $display("FAIL reset_bus got %0h want 0", {bus.M_BUS_ADD, bus.M_BUS_DATA_OUT}); end
  endtask

  task automatic test_main;
    int d0;
    cfg = 64'h0003FC00_00000000; fail_mode = 0;
    push_full(1'b1, 1'b0);
    push_fin(8'h2D, 1'b0);
    d0 = done_cnt;
    do_scan(1'b1, 1'b0, 50);
    checks++; if (sc_tmo) begin errors++; $display("FAIL main_timeout got no DONE want DONE"); end
    checks++; if (sc_lat != NT*24+4) begin errors++; $display("FAIL main_latency got %0d want %0d", sc_lat, NT*24+4); end
    checks++; if (sc_busy1 !== 1'b1) begin errors++; $display("FAIL main_busy_rise got %0b want 1", sc_busy1); end
    checks++; if (sc_busy_done !== 1'b0) begin errors++; $display("FAIL main_busy_at_done got %0b want 0", sc_busy_done); end
    repeat (4) @(negedge clk);
    checks++; if (best_tap !== 5'd13) begin errors++; $display("FAIL main_best_tap got %0d want 13", best_tap); end
    checks++; if (best_len !== 7'd8) begin errors++; $display("FAIL main_best_len got %0d want 8", best_len); end
    checks++; if (best_edge !== 1'b1) begin errors++; $display("FAIL main_best_edge got %0b want 1", best_edge); end
    checks++; if (fail_o !== 1'b0) begin errors++; $display("FAIL main_fail got %0b want 0", fail_o); end
    checks++; if (pass_map !== 64'h0003FC00_00000000) begin errors++; $display("FAIL main_pass_map got %0h want 3fc0000000000", pass_map); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL main_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL main_writes_left got %0d want 0", exp_wr.size()); end
  endtask

  task automatic test_all_fail;
    int d0;
    cfg = 64'd0; fail_mode = 1;
    push_full(1'b1, 1'b0);
    push_fin(8'h22, 1'b0);
    d0 = done_cnt;
    do_scan(1'b1, 1'b0, 0);
    checks++; if (sc_tmo) begin errors++; $display("FAIL fail_timeout got no DONE want DONE"); end
    checks++; if (sc_pmap1 !== 64'd0) begin errors++; $display("FAIL fail_map_cleared got %0h want 0", sc_pmap1); end
    repeat (4) @(negedge clk);
    checks++; if (fail_o !== 1'b1) begin errors++; $display("FAIL fail_flag got %0b want 1", fail_o); end
    checks++; if ({best_edge, best_tap, best_len} !== 13'd0) begin errors++; $display("FAIL fail_best got %0h want 0", {best_edge, best_tap, best_len}); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL fail_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL fail_writes_left got %0d want 0", exp_wr.size()); end
    fail_mode = 0;
  endtask

  task automatic test_tie;
    cfg = 64'h00000000_0070001C; fail_mode = 0;
    push_full(1'b0, 1'b1);
    push_fin(8'h03, 1'b1);
    do_scan(1'b0, 1'b1, 0);
    checks++; if (sc_tmo) begin errors++; $display("FAIL tie_timeout got no DONE want DONE"); end
    checks++; if (sc_fail1 !== 1'b0) begin errors++; $display("FAIL tie_fail_cleared got %0b want 0", sc_fail1); end
    repeat (4) @(negedge clk);
    checks++; if (best_tap !== 5'd3) begin errors++; $display("FAIL tie_best_tap got %0d want 3", best_tap); end
    checks++; if ({best_edge, best_len} !== {1'b0, 7'd3}) begin errors++; $display("FAIL tie_edge_len got %0h want 3", {best_edge, best_len}); end
    checks++; if (pass_map !== 64'h00000000_0070001C) begin errors++; $display("FAIL tie_pass_map got %0h want 70001c", pass_map); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL tie_writes_left got %0d want 0", exp_wr.size()); end
  endtask

  task automatic test_top_window;
    cfg = 64'h00000000_FE000000; fail_mode = 0;
    push_full(1'b0, 1'b0);
    push_fin(8'h1C, 1'b0);
    do_scan(1'b0, 1'b0, 0);
    checks++; if (sc_tmo) begin errors++; $display("FAIL top_timeout got no DONE want DONE"); end
    repeat (4) @(negedge clk);
    checks++; if (best_tap !== 5'd28) begin errors++; $display("FAIL top_best_tap got %0d want 28", best_tap); end
    checks++; if (best_len !== 7'd7) begin errors++; $display("FAIL top_best_len got %0d want 7", best_len); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL top_writes_left got %0d want 0", exp_wr.size()); end
  endtask

  task automatic test_abort;
    int r0, d0;
    cfg = 64'h6; fail_mode = 0;
    push_taps(1'b0, 0, 5, 1'b0);
    d0 = done_cnt;
    conf_edge = 1'b0; conf_inv = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (128) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
    r0 = rd_cnt;
    repeat (200) @(negedge clk);
    checks++; if (rd_cnt != r0) begin errors++; $display("FAIL abort_reads got %0d want 0", rd_cnt - r0); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt - d0); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL abort_writes_left got %0d want 0", exp_wr.size()); end
    checks++; if (pass_map !== 64'h6) begin errors++; $display("FAIL abort_pass_map got %0h want 6", pass_map); end
    checks++; if ({best_tap, best_len} !== {5'd1, 7'd2}) begin errors++; $display("FAIL abort_partial got tap %0d len %0d want tap 1 len 2", best_tap, best_len); end
    // START and ABORT together in IDLE: the scan must start
    push_w(32'd0, 8'h00);
    push_w(32'd7, 8'h00);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_beats_abort got busy %0b want 1", busy); end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort2_busy got %0b want 0", busy); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL abort2_writes_left got %0d want 0", exp_wr.size()); end
  endtask

  task automatic test_rst_mid;
    push_taps(1'b0, 0, 0, 1'b0);
    conf_edge = 1'b0; conf_inv = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    checks++; if (!(bus.M_BUS_RD === 1'b1 && bus.M_BUS_ADD === 32'd2)) begin errors++; $display("FAIL rd_stat_timing got rd %0b addr %0h want rd 1 addr 2", bus.M_BUS_RD, bus.M_BUS_ADD); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy, done, fail_o, bus.M_BUS_WR, bus.M_BUS_RD} !== 5'd0) begin errors++; $display("FAIL rst_mid_ctrl got %0b want 0", {busy, done, fail_o, bus.M_BUS_WR, bus.M_BUS_RD}); end
    checks++; if ({pass_map, best_tap, best_edge, best_len, bus.M_BUS_ADD, bus.M_BUS_DATA_OUT} !== '0) begin errors++; $display("FAIL rst_mid_data got map %0h add %0h want 0", pass_map, bus.M_BUS_ADD); end
    repeat (30) @(negedge clk);
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL rst_mid_writes_left got %0d want 0", exp_wr.size()); end
  endtask

`ifdef TAP_SCAN_BOTH_EDGES_EN
  task automatic test_both_edges;
    cfg = 64'h0000FF00_000003F0; fail_mode = 0;
    push_full(1'b0, 1'b0);
    push_fin(8'h2B, 1'b0);
    do_scan(1'b0, 1'b0, 0);
    checks++; if (sc_tmo) begin errors++; $display("FAIL both_timeout got no DONE want DONE"); end
    checks++; if (sc_lat != 1540) begin errors++; $display("FAIL both_latency got %0d want 1540", sc_lat); end
    repeat (4) @(negedge clk);
    checks++; if ({best_edge, best_tap, best_len} !== {1'b1, 5'd11, 7'd8}) begin errors++; $display("FAIL both_best got edge %0b tap %0d len %0d want 1 11 8", best_edge, best_tap, best_len); end
    checks++; if (pass_map !== 64'h0000FF00_000003F0) begin errors++; $display("FAIL both_pass_map got %0h want ff00000003f0", pass_map); end
    checks++; if (exp_wr.size() != 0) begin errors++; $display("FAIL both_writes_left got %0d want 0", exp_wr.size()); end
  endtask
`endif

  initial begin
    bus.M_BUS_DATA_IN = 8'h00;
    test_reset();
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
    test_main();
    $display("test_main done checks=%0d errors=%0d", checks, errors);
    test_all_fail();
    $display("test_all_fail done checks=%0d errors=%0d", checks, errors);
    test_tie();
    $display("test_tie done checks=%0d errors=%0d", checks, errors);
    test_top_window();
    $display("test_top_window done checks=%0d errors=%0d", checks, errors);
    test_abort();
    $display("test_abort done checks=%0d errors=%0d", checks, errors);
    test_rst_mid();
    $display("test_rst_mid done checks=%0d errors=%0d", checks, errors);
`ifdef TAP_SCAN_BOTH_EDGES_EN
    test_both_edges();
    $display("test_both_edges done checks=%0d errors=%0d", checks, errors);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
